// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with a
// one-entry registered result returned over per-requester valid/ready channels.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int CNTRL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [CNTRL_W-1:0] req0_cntrl,
  input  logic [WIDTH-1:0]   req0_in1,
  input  logic [WIDTH-1:0]   req0_in2,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [CNTRL_W-1:0] req1_cntrl,
  input  logic [WIDTH-1:0]   req1_in1,
  input  logic [WIDTH-1:0]   req1_in2,
  output logic [CNTRL_W-1:0] alu_cntrl,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_owner;
  logic             w_owner_nxt;
  logic             r_last_grant;
  logic             w_last_grant_nxt;
  logic [WIDTH-1:0] r_result_p1;
  logic             r_zero_p1;

  logic w_grant0;
  logic w_grant1;
  logic w_owner_ready;
  logic w_rsp_fire;
  logic w_can_issue;
  logic w_accept;

  // Tie goes to whichever requester did not win the previous accept.
  always_comb begin
    w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
    w_grant0 = req0_valid & ~w_grant1;
  end

  always_comb begin
    w_owner_ready = r_owner ? rsp1_ready : rsp0_ready;
    w_rsp_fire    = (r_state == FULL) & w_owner_ready;
    w_can_issue   = (r_state == IDLE) | w_rsp_fire;
    req0_ready    = w_grant0 & w_can_issue & ~reset;
    req1_ready    = w_grant1 & w_can_issue & ~reset;
    w_accept      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  end

  // With nobody granted the mux falls back to requester 0's fields.
  always_comb begin
    if (w_grant1) begin
      alu_cntrl = req1_cntrl;
      alu_in1   = req1_in1;
      alu_in2   = req1_in2;
    end else begin
      alu_cntrl = req0_cntrl;
      alu_in1   = req0_in1;
      alu_in2   = req0_in2;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt      = FULL;
          w_owner_nxt      = w_grant1;
          w_last_grant_nxt = w_grant1;
        end
      end
      FULL: begin
        if (w_accept) begin
          w_state_nxt      = FULL;
          w_owner_nxt      = w_grant1;
          w_last_grant_nxt = w_grant1;
        end else if (w_rsp_fire) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: ALU output captured on the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_result_p1  <= '0;
      r_zero_p1    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      if (w_accept) begin
        r_result_p1 <= alu_result;
        r_zero_p1   <= alu_zero;
      end
    end
  end

  always_comb begin
    rsp0_valid = (r_state == FULL) & ~r_owner;
    rsp1_valid = (r_state == FULL) & r_owner;
    rsp_result = r_result_p1;
    rsp_zero   = r_zero_p1;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter; a transaction-level
// reference (pending-response queue, last winner) predicts every output.
module tb_alu_share_arbiter;
  localparam int WIDTH   = 32;
  localparam int CNTRL_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               req0_valid, req1_valid;
  logic               req0_ready, req1_ready;
  logic [CNTRL_W-1:0] req0_cntrl, req1_cntrl;
  logic [WIDTH-1:0]   req0_in1, req0_in2, req1_in1, req1_in2;
  logic [CNTRL_W-1:0] alu_cntrl;
  logic [WIDTH-1:0]   alu_in1, alu_in2, alu_result;
  logic               alu_zero;
  logic               rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zero;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .CNTRL_W(CNTRL_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cntrl(req0_cntrl),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cntrl(req1_cntrl),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .alu_cntrl(alu_cntrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  function automatic logic [WIDTH-1:0] ref_alu(input logic [CNTRL_W-1:0] c,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return '0;
    endcase
  endfunction

  // Stand-in for the existing combinational ALU.
  always_comb begin
    alu_result = ref_alu(alu_cntrl, alu_in1, alu_in2);
    alu_zero   = (alu_result == '0);
  end

  typedef struct packed {
    logic             owner;
    logic [WIDTH-1:0] res;
    logic             zero;
  } rsp_t;

  rsp_t pend[$];
  bit   last_win;
  bit   res_clear;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    pend.delete();
    last_win  = 1'b1;
    res_clear = 1'b1;
  endtask

  // Called at a negedge with inputs applied; checks, advances model, returns at next negedge.
  task automatic tick(input string tag);
    bit   busy, own, drained, free;
    int   w;
    rsp_t e;
    #1;
    busy    = (pend.size() != 0);
    own     = busy ? pend[0].owner : 1'b0;
    drained = busy && (own ? rsp1_ready : rsp0_ready);
    free    = !busy || drained;
    w = -1;
    if (req0_valid && req1_valid) w = last_win ? 0 : 1;
    else if (req0_valid)          w = 0;
    else if (req1_valid)          w = 1;
    chk({tag, ".req0_ready"}, 64'(req0_ready), 64'(!reset && free && w == 0));
    chk({tag, ".req1_ready"}, 64'(req1_ready), 64'(!reset && free && w == 1));
    chk({tag, ".rsp0_valid"}, 64'(rsp0_valid), 64'(busy && !own));
    chk({tag, ".rsp1_valid"}, 64'(rsp1_valid), 64'(busy && own));
    if (busy) begin
      chk({tag, ".rsp_result"}, 64'(rsp_result), 64'(pend[0].res));
      chk({tag, ".rsp_zero"}, 64'(rsp_zero), 64'(pend[0].zero));
    end else if (res_clear) begin
      chk({tag, ".rsp_result_clr"}, 64'(rsp_result), 64'd0);
      chk({tag, ".rsp_zero_clr"}, 64'(rsp_zero), 64'd0);
    end
    if (reset) begin
      model_reset();
    end else begin
      if (drained) void'(pend.pop_front());
      if (w >= 0 && free) begin
        e.owner = (w == 1);
        e.res   = (w == 1) ? ref_alu(req1_cntrl, req1_in1, req1_in2)
                           : ref_alu(req0_cntrl, req0_in1, req0_in2);
        e.zero  = (e.res == '0);
        pend.push_back(e);
        last_win  = (w == 1);
        res_clear = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [CNTRL_W-1:0] ops [4];

  initial begin
    ops[0] = 4'b0010; ops[1] = 4'b0110; ops[2] = 4'b0000; ops[3] = 4'b0001;
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_cntrl = '0; req0_in1 = '0; req0_in2 = '0;
    req1_cntrl = '0; req1_in1 = '0; req1_in2 = '0;
    repeat (2) @(negedge clk);
    model_reset();
    chk("reset.rsp0_valid", 64'(rsp0_valid), 64'd0);
    chk("reset.rsp1_valid", 64'(rsp1_valid), 64'd0);
    chk("reset.rsp_result", 64'(rsp_result), 64'd0);
    chk("reset.rsp_zero", 64'(rsp_zero), 64'd0);
    chk("reset.req0_ready", 64'(req0_ready), 64'd0);
    reset = 1'b0;

    // Single issue
    req0_valid = 1; req0_cntrl = 4'b0010; req0_in1 = 1; req0_in2 = 2; rsp0_ready = 1;
    tick("single");
    chk("single.valid", 64'(rsp0_valid), 64'd1);
    chk("single.result", 64'(rsp_result), 64'd3);
    chk("single.zero", 64'(rsp_zero), 64'd0);
    chk("single.rsp1", 64'(rsp1_valid), 64'd0);
    req0_valid = 0;
    tick("single_drain");

    // Simultaneous requests right after reset
    reset = 1;
    tick("rst2");
    reset = 0;
    req0_valid = 1; req0_cntrl = 4'b0110; req0_in1 = 10; req0_in2 = 2;
    req1_valid = 1; req1_cntrl = 4'b0000; req1_in1 = 1;  req1_in2 = 2;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick("alt");
      chk("alt.owner0", 64'(rsp0_valid), 64'(i % 2 == 0));
      chk("alt.result", 64'(rsp_result), (i % 2 == 0) ? 64'd8 : 64'd0);
      chk("alt.zero", 64'(rsp_zero), 64'(i % 2 == 1));
    end
    req0_valid = 0; req1_valid = 0;
    tick("alt_drain");

    // Backpressure on requester 1
    req1_valid = 1; req1_cntrl = 4'b0010; req1_in1 = 12; req1_in2 = 2; rsp1_ready = 0;
    tick("bp_issue");
    req1_valid = 0;
    req0_valid = 1; req0_cntrl = 4'b0010; req0_in1 = 5; req0_in2 = 5; rsp0_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.req0_ready", 64'(req0_ready), 64'd0);
      chk("bp.rsp1_valid", 64'(rsp1_valid), 64'd1);
      chk("bp.result", 64'(rsp_result), 64'd14);
      tick("bp_hold");
    end
    rsp1_ready = 1;
    #1;
    chk("bp.release_ready", 64'(req0_ready), 64'd1);
    tick("bp_release");
    chk("bp.next_result", 64'(rsp_result), 64'd10);
    req0_valid = 0;
    tick("bp_drain");

    // Back-to-back throughput
    req0_valid = 1; req0_cntrl = 4'b0010; rsp0_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      req0_in1 = k; req0_in2 = k;
      tick("b2b");
      chk("b2b.valid", 64'(rsp0_valid), 64'd1);
      chk("b2b.result", 64'(rsp_result), 64'(2 * k));
    end
    req0_valid = 0;
    tick("b2b_drain");

    // Reset while a result is held
    req0_valid = 1; req0_cntrl = 4'b0010; req0_in1 = 7; req0_in2 = 0; rsp0_ready = 0;
    tick("mid_issue");
    req0_valid = 0; reset = 1;
    tick("mid_reset");
    reset = 0;
    chk("mid.rsp0_valid", 64'(rsp0_valid), 64'd0);
    chk("mid.rsp_result", 64'(rsp_result), 64'd0);
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    tick("mid_tie");
    chk("mid.tie_req0", 64'(rsp0_valid), 64'd1);
    req0_valid = 0; req1_valid = 0;
    tick("mid_drain");

    // Idle cycles leave the pointer alone
    for (int i = 0; i < 5; i++) begin
      tick("idle");
      chk("idle.none", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    end
    req0_valid = 1; req1_valid = 1;
    tick("idle_tie");
    chk("idle.tie_req1", 64'(rsp1_valid), 64'd1);
    req0_valid = 0; req1_valid = 0;
    tick("idle_drain");

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      rsp0_ready = reset ? 1'b0 : ($urandom_range(0, 3) != 0);
      rsp1_ready = reset ? 1'b0 : ($urandom_range(0, 3) != 0);
      req0_cntrl = ops[$urandom_range(0, 3)];
      req1_cntrl = ops[$urandom_range(0, 3)];
      req0_in1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      req0_in2 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      req1_in1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      req1_in2 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single-cycle ALU between two requesters, e.g. the execute stage (req 0) and the branch/address unit (req 1).
- Arbitrates between them round-robin and drives the ALU operand and control inputs.
- Registers the ALU result and Zero flag, and returns them to the requester that issued the operation through a valid/ready response handshake.
- Sits between the requesters and the existing ALU instance; the ALU stays combinational and unmodified.

Parameters:
WIDTH, 32, operand/result width
CNTRL_W, 4, ALU control code width (0010 add, 0110 sub, 0000 and, 0001 or)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_cntrl  input  CNTRL_W  requester 0 ALU control code
req0_in1  input  WIDTH  requester 0 operand 1
req0_in2  input  WIDTH  requester 0 operand 2
req1_valid, req1_ready, req1_cntrl, req1_in1, req1_in2  as above, requester 1
alu_cntrl  output  CNTRL_W  to ALU ALU_Cntrl
alu_in1  output  WIDTH  to ALU In1
alu_in2  output  WIDTH  to ALU In2
alu_result  input  WIDTH  from ALU ALU_Result
alu_zero  input  1  from ALU Zero
rsp0_valid  output  1  result pending for requester 0
rsp0_ready  input  1  requester 0 takes result
rsp1_valid  output  1  result pending for requester 1
rsp1_ready  input  1  requester 1 takes result
rsp_result  output  WIDTH  registered result, shared by both response channels
rsp_zero  output  1  registered Zero flag

Behaviour:
- Reset is synchronous and active-high on clk. While reset is high at a rising edge:
  - state goes to IDLE; rsp0_valid, rsp1_valid, rsp_result and rsp_zero clear to 0;
  - last_grant is set to 1, so requester 0 wins the first tie.
- Reset mid-operation discards any pending result with no response issued. req_ready is 0 during any cycle in which reset is high.
- State machine:
  - IDLE: no result held. Goes to FULL on accept.
  - FULL: result held for owner o (0 or 1). Goes to IDLE on rsp_fire without accept; stays FULL on rsp_fire with accept (new owner); stays FULL while rspo_ready is low.
- rsp_fire = rspo_valid & rspo_ready.
- can_issue = (state==IDLE) | rsp_fire.
- Grant (combinational):
  - if only one req_valid is high, that requester is granted;
  - if both are high, the requester not equal to last_grant is granted;
  - reqX_ready = grantX & can_issue & ~reset.
- Accept: reqX_valid & reqX_ready. At most one accept per cycle.
- alu_cntrl/in1/in2 mux the granted requester's fields. With no valid requester they drive requester 0's fields; outputs are don't-care but must be deterministic.
- Latency: operation accepted in cycle N; alu_result/alu_zero are registered at the end of cycle N; rspX_valid is high from cycle N+1.
- Throughput: 1 operation/cycle when the owner holds rsp_ready high.
- rsp_result/rsp_zero are stable while rspX_valid is high and not yet fired. Only the owner's rspX_valid is high; the other is 0.
- last_grant updates only on accept. No pointer change on idle or stalled cycles.
- Backpressure: while FULL and the owner's rsp_ready is low, both req_ready are 0. Requester inputs must be held by the requesters.
- Handshake rules:
  - reqX_ready may depend combinationally on both req_valid inputs, on rsp ready and on state.
  - Requesters must not make req_valid depend on req_ready.
  - A requester may drop req_valid before acceptance; no operation is issued in that case.
- No arithmetic is performed here. Results and Zero pass through the ALU exactly. Width is fixed by WIDTH, with no truncation.

Test Plan:
- Single issue:
  - req0: cntrl=0010, in1=1, in2=2, rsp0_ready=1.
  - Expect req0_ready=1 in cycle N; in N+1, rsp0_valid=1, rsp_result=3, rsp_zero=0, rsp1_valid=0.
- Simultaneous requests after reset:
  - req0 sub 10-2 and req1 and 1&2, both held valid, both rsp_ready=1.
  - Expect grant order req0 (result 8), then req1 (result 0, zero=1), then req0 again, strictly alternating, one accept per cycle.
- Backpressure:
  - req1 issues add 12+2 with rsp1_ready=0 for 3 cycles while req0 is valid.
  - Expect rsp1_valid=1 and rsp_result=14 stable for 3 cycles, req0_ready=0 throughout.
  - On rsp1_ready=1, req0 is accepted in the same cycle.
- Back-to-back throughput: 4 consecutive req0 adds (k+k, k=1..4) with rsp0_ready=1 → results 2, 4, 6, 8 on consecutive cycles, no bubbles.
- Reset mid-operation:
  - assert reset for 1 cycle while FULL with rsp0_ready=0.
  - Expect rsp0_valid=0 the next cycle, no response delivered, req0 winning the next tie.
- Idle: no req_valid for 5 cycles → both rspX_valid=0 and last_grant unchanged; the next tie goes to the requester that did not win last.
